// File: rtl/fsm_q3c_pkg.sv
// Shared types, state encodings and decode functions for the q3c lane FSM.
// The optional state-load port set is enabled with the FSM_STATE_LOAD_EN macro.
package fsm_q3c_pkg;

  typedef logic [2:0] q3c_state_t;

  localparam q3c_state_t S_A = 3'b000;
  localparam q3c_state_t S_B = 3'b001;
  localparam q3c_state_t S_C = 3'b010;
  localparam q3c_state_t S_D = 3'b011;
  localparam q3c_state_t S_E = 3'b100;

  // Next-state table of the q3c machine; codes 101..111 fall back to S_A
  // so a corrupted lane recovers in one advance.
  function automatic q3c_state_t q3c_next(input q3c_state_t state, input logic x);
    q3c_state_t nxt;
    case (state)
      S_A:     nxt = x ? S_B : S_A;
      S_B:     nxt = x ? S_E : S_B;
      S_C:     nxt = x ? S_B : S_C;
      S_D:     nxt = x ? S_C : S_B;
      S_E:     nxt = x ? S_E : S_D;
      default: nxt = S_A;
    endcase
    return nxt;
  endfunction

  // Moore output: asserted only in S_D and S_E.
  function automatic logic q3c_z(input q3c_state_t state);
    return (state == S_D) || (state == S_E);
  endfunction

  // True for the three unused encodings.
  function automatic logic q3c_illegal(input q3c_state_t state);
    return state > S_E;
  endfunction

endpackage

// File: rtl/fsm_q3c_lane.sv
// One q3c channel: state register, z-entry event counter and sticky
// illegal-state flag. TRACK_ILLEGAL=0 ties the flag low for builds where
// illegal codes cannot be reached (FSM_STATE_LOAD_EN undefined).
module fsm_q3c_lane
  import fsm_q3c_pkg::*;
#(
  parameter int CNT_W         = 8,
  parameter bit TRACK_ILLEGAL = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             x,
  input  logic             cnt_clr,
  input  logic             ld,
  input  logic [2:0]       ld_val,
  output logic [2:0]       state,
  output logic             y0,
  output logic             z,
  output logic [CNT_W-1:0] z_cnt,
  output logic             illegal
);

  q3c_state_t state_q;
  q3c_state_t state_d;
  q3c_state_t table_next;
  logic       entry;

  // Next state: a load overrides everything, otherwise advance only when enabled.
  always_comb begin
    table_next = q3c_next(state_q, x);
    state_d    = state_q;
    if (ld) begin
      state_d = ld_val;
    end else if (en) begin
      state_d = table_next;
    end
  end

  // State register with synchronous reset to S_A.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_A;
    end else begin
      state_q <= state_d;
    end
  end

  // Outputs: Moore z from the registered state, y0 from the raw table entry.
  always_comb begin
    z     = q3c_z(state_q);
    y0    = table_next[0];
    state = state_q;
    entry = !q3c_z(state_q) && q3c_z(state_d);
  end

  // Saturating count of entries into {S_D, S_E}; clear beats increment.
  always_ff @(posedge clk) begin
    if (reset || cnt_clr) begin
      z_cnt <= '0;
    end else if (entry && (z_cnt != {CNT_W{1'b1}})) begin
      z_cnt <= z_cnt + CNT_W'(1);
    end
  end

  generate
    if (TRACK_ILLEGAL) begin : g_illegal
      logic illegal_q;

      // Sticky flag set on the edge the register takes an illegal code.
      always_ff @(posedge clk) begin
        if (reset) begin
          illegal_q <= 1'b0;
        end else if (q3c_illegal(state_d)) begin
          illegal_q <= 1'b1;
        end
      end

      assign illegal = illegal_q;
    end else begin : g_no_illegal
      assign illegal = 1'b0;
    end
  endgenerate

endmodule

// File: rtl/fsm_q3c_multi.sv
// N_CH independent q3c lanes with load steering, output packing and any_z.
// Define FSM_STATE_LOAD_EN to add the ld/ld_ch/ld_val state-load ports.
module fsm_q3c_multi
  import fsm_q3c_pkg::*;
#(
  parameter int N_CH  = 4,
  parameter int CNT_W = 8,
  localparam int LD_W = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [N_CH-1:0]       en,
  input  logic [N_CH-1:0]       x,
  input  logic                  cnt_clr,
`ifdef FSM_STATE_LOAD_EN
  input  logic                  ld,
  input  logic [LD_W-1:0]       ld_ch,
  input  logic [2:0]            ld_val,
`endif
  output logic [3*N_CH-1:0]     state_o,
  output logic [N_CH-1:0]       y0_o,
  output logic [N_CH-1:0]       z,
  output logic [CNT_W*N_CH-1:0] z_cnt,
  output logic                  any_z,
  output logic [N_CH-1:0]       illegal_o
);

`ifdef FSM_STATE_LOAD_EN
  localparam bit TRACK_ILLEGAL = 1'b1;
`else
  localparam bit TRACK_ILLEGAL = 1'b0;
`endif

  logic [N_CH-1:0] lane_ld;
  q3c_state_t      lane_ld_val;

  genvar i;
  generate
    for (i = 0; i < N_CH; i++) begin : g_lane
`ifdef FSM_STATE_LOAD_EN
      // ld_ch values at or above N_CH match no lane and are dropped.
      assign lane_ld[i] = ld && (ld_ch == LD_W'(i));
`else
      assign lane_ld[i] = 1'b0;
`endif

      fsm_q3c_lane #(
        .CNT_W         (CNT_W),
        .TRACK_ILLEGAL (TRACK_ILLEGAL)
      ) u_lane (
        .clk     (clk),
        .reset   (reset),
        .en      (en[i]),
        .x       (x[i]),
        .cnt_clr (cnt_clr),
        .ld      (lane_ld[i]),
        .ld_val  (lane_ld_val),
        .state   (state_o[3*i +: 3]),
        .y0      (y0_o[i]),
        .z       (z[i]),
        .z_cnt   (z_cnt[CNT_W*i +: CNT_W]),
        .illegal (illegal_o[i])
      );
    end
  endgenerate

`ifdef FSM_STATE_LOAD_EN
  assign lane_ld_val = ld_val;
`else
  assign lane_ld_val = S_A;
`endif

  assign any_z = |z;

endmodule

// File: doc/fsm_q3c_multi.md
Name: fsm_q3c_multi

Overview:
- Parametrised, registered successor to the 2014 q3c next-state/output decode.
- Runs N_CH independent copies of the 5-state q3c Moore FSM (states 3'b000..3'b100) with:
  - a registered state per channel;
  - a per-channel enable;
  - illegal-state recovery;
  - a saturating count of z assertions per channel.
- Used as a multi-lane sequence detector.
- Its next-state/output decode is the golden lane function for the bench.

Parameters:
- N_CH, 4, number of independent FSM channels (1..16).
- CNT_W, 8, width of each per-channel z-event counter.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- en  input  N_CH  per-channel advance enable; state holds when 0.
- x  input  N_CH  per-channel FSM input bit.
- cnt_clr  input  1  synchronous clear of all z-event counters.
- state_o  output  3*N_CH  registered state; channel i at [3i+2:3i].
- y0_o  output  N_CH  combinational bit 0 of the next state for channel i (given current state and x[i]).
- z  output  N_CH  Moore output; decode of registered state.
- z_cnt  output  CNT_W*N_CH  per-channel saturating z rising-edge count; channel i at [CNT_W*i+CNT_W-1:CNT_W*i].
- any_z  output  1  OR of all z bits.
- illegal_o  output  N_CH  sticky flag: channel held an illegal code (101/110/111).
- Load ports, present only with FSM_STATE_LOAD_EN:
  - ld  input  1  state load strobe.
  - ld_ch  input  $clog2(N_CH) (min 1)  target channel.
  - ld_val  input  3  state value to load.

Behaviour:
- Reset (synchronous, active-high) outranks everything. On reset:
  - all state = 000;
  - all z_cnt = 0;
  - all illegal_o = 0.
  - Outputs after reset: z = 0, any_z = 0, y0_o = x.
- Per-channel next-state table. Format: cur: next(x=0) / next(x=1).
  - 000: 000 / 001
  - 001: 001 / 100
  - 010: 010 / 001
  - 011: 001 / 010
  - 100: 011 / 100
  - illegal codes: 000 / 000 (one-cycle recovery).
- State register update on each clk:
  - state <= next if en[i]=1;
  - state holds if en[i]=0.
  - Latency from x to state_o is 1 cycle.
- z[i] = 1 iff state is 011 or 100; otherwise 0, illegal codes included (no X on outputs).
- y0_o[i] = bit 0 of the table entry, independent of en[i].
- z-event counter:
  - z_cnt[i] increments when z transitions 0->1 in the registered domain, i.e. the channel enters {011,100} from outside that set.
  - Saturates at 2^CNT_W-1.
  - Transitions 011<->100 and holds inside {011,100} do not count.
- cnt_clr zeroes all counters.
  - If cnt_clr coincides with an entry event, the result is 0: clear wins over increment.
- illegal_o[i] sets when the registered state is 101/110/111. It clears only on reset.
- Unused channels do not exist; N_CH is exact.

Optional Feature:
- Macro: FSM_STATE_LOAD_EN.
- When defined:
  - ld/ld_ch/ld_val ports exist.
  - When ld=1 and not reset, channel ld_ch loads ld_val, overriding en and the table that cycle.
  - Other channels advance normally.
  - ld_ch >= N_CH is ignored.
  - A load entering {011,100} from outside counts as a z event.
  - Loading an illegal code is the only way to exercise recovery and illegal_o.
- When undefined:
  - ports are absent;
  - illegal codes are unreachable;
  - the recovery rows remain in RTL for robustness;
  - illegal_o is tied 0.

Decomposition:
- Package fsm_q3c_pkg holds:
  - typedef q3c_state_t (3-bit);
  - named constants S_A=000, S_B=001, S_C=010, S_D=011, S_E=100;
  - function q3c_next(state, x);
  - function q3c_z(state).
- Sub-module fsm_q3c_lane: one channel covering the state register, counter and illegal flag.
  - Instantiated N_CH times via generate in fsm_q3c_multi.
  - The top contains only load steering, packing and any_z.

Test Plan:
- Reset sequencing: N_CH=4, reset 2 cycles, en=4'hF.
  - Drive channel 0 with x = 1,1,0,0,0.
  - Expected states: 001,100,011,001,001.
  - Expected z: 0,1,1,0,0.
  - Expected z_cnt[0] = 1 after the sequence.
- Enable hold: en[1]=0 for 3 cycles with x[1]=1 from state 001.
  - state_o[1] stays 001.
  - y0_o[1] = 0 throughout (next would be 100).
- Saturation: CNT_W=2; cycle channel 2 through 000->001->100->011->001 repeatedly.
  - z_cnt[2] reaches 3 after 3 entries and stays 3.
  - cnt_clr together with an entry gives 0.
- No count inside the output set: path 100->011->010->001 with x = 0,1,1.
  - 100->011 does not increment z_cnt.
  - z drops only at 010.
  - any_z tracks OR of all z bits.
- Illegal-state recovery (FSM_STATE_LOAD_EN): ld=1, ld_ch=3, ld_val=110.
  - Next cycle: state_o[3]=110, z[3]=0, illegal_o[3]=1.
  - Following cycle: state 000.
  - illegal_o[3] stays 1 until reset.
- Mid-operation reset: reset asserted in the same cycle as ld and cnt_clr while channels sit in 100.
  - All state 000, counters 0, flags 0 on the next edge.
